// File: rtl/riscv_mem_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// riscv_mem_pkg : shared types and constants for the unified-memory arbiter
// Rev 1.0
//------------------------------------------------------------------------------
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        D    = 2'd2
    } owner_e;

    localparam int DEF_AWIDTH = 12;
    localparam int DEF_DWIDTH = 32;

    // Memory strobes are active low
    localparam logic CSN_ON  = 1'b0;
    localparam logic CSN_OFF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
//------------------------------------------------------------------------------
// mem_arb_starve_ctr : saturating count of consecutive denied fetch cycles
// Rev 1.0
//------------------------------------------------------------------------------
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    logic [CNT_W-1:0] r_cnt;

    assign o_at_limit = (r_cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// riscv_mem_arbiter : fetch/data arbiter for one single-port synchronous SRAM
// Optional perf counters enabled by RISCV_MEM_ARB_PERF_EN.  Rev 1.0
//------------------------------------------------------------------------------
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AWIDTH       = DEF_AWIDTH,
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              I_REQ,
    input  logic [AWIDTH-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [DWIDTH-1:0] I_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [AWIDTH-1:0] D_ADDR,
    input  logic [DWIDTH-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [DWIDTH-1:0] D_RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [DWIDTH-1:0] MEM_DI,
    input  logic [DWIDTH-1:0] MEM_DOUT
`ifdef RISCV_MEM_ARB_PERF_EN
    ,
    output logic [31:0]       CONFLICT_CNT,
    output logic [31:0]       STARVE_CNT
`endif
);

    logic              w_at_limit;
    logic              w_i_win;
    logic              w_d_win;
    logic [AWIDTH-1:0] r_last_addr;
    owner_e            r_rd_owner;

    // Data has priority unless fetch has been starved up to the limit
    assign w_i_win = I_REQ & (~D_REQ | w_at_limit);
    assign w_d_win = D_REQ & ~w_i_win;

    assign I_GNT = RSTn & w_i_win;
    assign D_GNT = RSTn & w_d_win;

    assign MEM_CSN = (I_GNT | D_GNT) ? CSN_ON : CSN_OFF;
    assign MEM_WEN = (D_GNT & D_WE)  ? CSN_ON : CSN_OFF;

    always_comb begin
        MEM_ADDR = r_last_addr;
        MEM_DI   = '0;
        if (I_GNT) begin
            MEM_ADDR = I_ADDR;
        end else if (D_GNT) begin
            MEM_ADDR = D_ADDR;
            MEM_DI   = D_WDATA;
        end
    end

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_ctr (
        .clk        (CLK),
        .rst_n      (RSTn),
        .i_clr      (~I_REQ | I_GNT),
        .i_inc      (I_REQ & ~I_GNT),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_last_addr <= '0;
            r_rd_owner  <= NONE;
        end else begin
            if (I_GNT) begin
                r_last_addr <= I_ADDR;
            end else if (D_GNT) begin
                r_last_addr <= D_ADDR;
            end
            if (I_GNT) begin
                r_rd_owner <= I;
            end else if (D_GNT && !D_WE) begin
                r_rd_owner <= D;
            end else begin
                r_rd_owner <= NONE;
            end
        end
    end

    // Response flags are masked while reset is held so a pending read is dropped
    assign I_RVALID = RSTn & (r_rd_owner == I);
    assign D_RVALID = RSTn & (r_rd_owner == D);
    assign I_RDATA  = MEM_DOUT;
    assign D_RDATA  = MEM_DOUT;

`ifdef RISCV_MEM_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_starve_cnt;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_conflict_cnt <= '0;
            r_starve_cnt   <= '0;
        end else begin
            if (I_REQ && D_REQ) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
            if (I_GNT && D_REQ) begin
                r_starve_cnt <= r_starve_cnt + 32'd1;
            end
        end
    end

    assign CONFLICT_CNT = r_conflict_cnt;
    assign STARVE_CNT   = r_starve_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_riscv_mem_arbiter : directed and randomized check of riscv_mem_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
module tb_riscv_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_req = 1'b0;
    logic [11:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [11:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_dout = '0;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_csn, mem_wen;
    logic [31:0] i_rdata, d_rdata, mem_di;
    logic [11:0] mem_addr;
`ifdef RISCV_MEM_ARB_PERF_EN
    logic [31:0] conflict_cnt, starve_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model predictions for the current cycle, also used to hold ungranted requests
    bit e_ig = 1'b0;
    bit e_dg = 1'b0;

    riscv_mem_arbiter #(
        .AWIDTH       (12),
        .DWIDTH       (32),
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (3)
    ) dut (
        .CLK      (clk),
        .RSTn     (rstn),
        .I_REQ    (i_req),
        .I_ADDR   (i_addr),
        .I_GNT    (i_gnt),
        .I_RVALID (i_rvalid),
        .I_RDATA  (i_rdata),
        .D_REQ    (d_req),
        .D_WE     (d_we),
        .D_ADDR   (d_addr),
        .D_WDATA  (d_wdata),
        .D_GNT    (d_gnt),
        .D_RVALID (d_rvalid),
        .D_RDATA  (d_rdata),
        .MEM_CSN  (mem_csn),
        .MEM_WEN  (mem_wen),
        .MEM_ADDR (mem_addr),
        .MEM_DI   (mem_di),
        .MEM_DOUT (mem_dout)
`ifdef RISCV_MEM_ARB_PERF_EN
        ,
        .CONFLICT_CNT (conflict_cnt),
        .STARVE_CNT   (starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4) return 32'h0050_0093;
        return (32'(idx) * 32'h0001_0003) ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port synchronous SRAM, read data one cycle after the strobe
    initial begin : p_sram
        logic [31:0] sram [0:WORDS-1];
        for (int i = 0; i < WORDS; i++) sram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_csn === 1'b0) begin
                if (mem_wen === 1'b0) sram[mem_addr[11:2]] = mem_di;
                else                  mem_dout <= sram[mem_addr[11:2]];
            end
        end
    end

    // Behavioural reference: predicts every output each cycle from the rules
    initial begin : p_model
        logic [31:0] ref_mem [0:WORDS-1];
        int          denied;
        int          pend;
        logic [31:0] pdata;
        logic [11:0] last;
        denied = 0; pend = 0; pdata = '0; last = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rstn) begin
                e_ig = 1'b0;
                e_dg = 1'b0;
            end else begin
                e_ig = (i_req && d_req) ? (denied >= LIMIT) : i_req;
                e_dg = d_req && !e_ig;
            end
            chk("i_gnt", 32'(i_gnt), 32'(e_ig));
            chk("d_gnt", 32'(d_gnt), 32'(e_dg));
            chk("mem_csn", 32'(mem_csn), 32'(!(e_ig || e_dg)));
            chk("mem_wen", 32'(mem_wen), 32'(!(e_dg && d_we)));
            chk("mem_addr", 32'(mem_addr), 32'(e_ig ? i_addr : (e_dg ? d_addr : last)));
            if (!e_ig && !e_dg) chk("mem_di_idle", mem_di, 32'h0);
            if (e_dg && d_we)   chk("mem_di_wr", mem_di, d_wdata);
            chk("i_rvalid", 32'(i_rvalid), 32'(rstn && pend == 1));
            chk("d_rvalid", 32'(d_rvalid), 32'(rstn && pend == 2));
            if (rstn && pend == 1) chk("i_rdata", i_rdata, pdata);
            if (rstn && pend == 2) chk("d_rdata", d_rdata, pdata);
            if (!rstn) begin
                denied = 0; pend = 0; last = '0;
            end else begin
                denied = (i_req && !e_ig) ? ((denied + 1 > LIMIT) ? LIMIT : denied + 1) : 0;
                pend   = e_ig ? 1 : ((e_dg && !d_we) ? 2 : 0);
                if (e_ig)                 pdata = ref_mem[i_addr[11:2]];
                else if (e_dg && !d_we)   pdata = ref_mem[d_addr[11:2]];
                if (e_dg && d_we)         ref_mem[d_addr[11:2]] = d_wdata;
                if (e_ig)      last = i_addr;
                else if (e_dg) last = d_addr;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] rand_addr();
        logic [9:0] w;
        logic [1:0] b;
        w = 10'($urandom_range(0, 63));
        b = 2'($urandom_range(0, 3));
        return {w, b};
    endfunction

    initial begin : p_stim
        // Reset held with both requesters active
        for (int k = 0; k < 3; k++) begin
            cyc();
            rstn = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            i_addr = 12'h010; d_addr = 12'h020;
            #1;
            chk("rst_i_gnt", 32'(i_gnt), 32'h0);
            chk("rst_d_gnt", 32'(d_gnt), 32'h0);
            chk("rst_csn", 32'(mem_csn), 32'h1);
            chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        end
        // Release into sustained conflict: D,D,D,D,I repeating
        for (int k = 0; k < 10; k++) begin
            cyc();
            rstn = 1'b1;
            #1;
            chk("starve_i_gnt", 32'(i_gnt), 32'(k % 5 == 4));
            chk("starve_d_gnt", 32'(d_gnt), 32'(k % 5 != 4));
        end
        cyc();
        i_req = 1'b0; d_req = 1'b0;
        #1;
        chk("starve_last_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("starve_last_i_rdata", i_rdata, 32'h0050_0093);
`ifdef RISCV_MEM_ARB_PERF_EN
        chk("perf_conflict", conflict_cnt, 32'd10);
        chk("perf_starve", starve_cnt, 32'd2);
`endif
        // Fetch-only read
        cyc();
        i_req = 1'b1; i_addr = 12'h010;
        #1;
        chk("fetch_gnt", 32'(i_gnt), 32'h1);
        cyc();
        i_req = 1'b0;
        #1;
        chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
        chk("fetch_rdata", i_rdata, 32'h0050_0093);
        chk("fetch_d_rvalid", 32'(d_rvalid), 32'h0);
        // Data write then read back
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'hEF0; d_wdata = 32'h0000_0EEC;
        #1;
        chk("wr_wen", 32'(mem_wen), 32'h0);
        chk("wr_gnt", 32'(d_gnt), 32'h1);
        cyc();
        d_we = 1'b0;
        #1;
        chk("rd_wen", 32'(mem_wen), 32'h1);
        chk("wr_no_rvalid", 32'(d_rvalid), 32'h0);
        cyc();
        d_req = 1'b0;
        #1;
        chk("rd_rvalid", 32'(d_rvalid), 32'h1);
        chk("rd_rdata", d_rdata, 32'h0000_0EEC);
        chk("idle_wen", 32'(mem_wen), 32'h1);
        // Build up starvation, then reset during a data read request
        for (int k = 0; k < 3; k++) begin
            cyc();
            i_req = 1'b1; d_req = 1'b1; d_addr = 12'h020;
            #1;
        end
        cyc();
        rstn = 1'b0; i_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
        #1;
        chk("midrst_d_gnt", 32'(d_gnt), 32'h0);
        chk("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            rstn = 1'b1; i_req = 1'b1; d_req = 1'b1;
            #1;
            if (k == 0) chk("midrst_next_d_rvalid", 32'(d_rvalid), 32'h0);
            chk("midrst_cnt_i_gnt", 32'(i_gnt), 32'(k == 4));
        end
        cyc();
        i_req = 1'b0; d_req = 1'b0;
        // Randomized traffic; ungranted requests are held stable
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rstn = ($urandom_range(0, 99) != 0);
            if (!i_req || e_ig) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = rand_addr();
            end
            if (!d_req || e_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 1) != 0);
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
        end
        cyc();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
